// File: rtl/seg7_capture.sv
// Seven-segment display scraper: debounces a multiplexed active-low LED bus and
// emits complete hex frames with valid/ready. Define SEG7_CAPTURE_OVERRUN_EN for the sticky overrun flag.
module seg7_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            not_segs,
    input  logic [DIGITS-1:0]     not_digit_en,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     invalid_mask,
    output logic                  value_valid,
    input  logic                  value_ready,
    output logic                  overrun
);

    localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);

    function automatic logic one_hot(input logic [DIGITS-1:0] x);
        int n;
        n = 0;
        for (int i = 0; i < DIGITS; i++) n += int'(x[i]);
        return (n == 1);
    endfunction

    // Returns {invalid, nibble}; unknown glyphs map to nibble 0.
    function automatic logic [4:0] decode(input logic [6:0] segs_n);
        logic [6:0] on;
        on = ~segs_n;
        case (on)
            7'h3F:   return 5'h00;
            7'h06:   return 5'h01;
            7'h5B:   return 5'h02;
            7'h4F:   return 5'h03;
            7'h66:   return 5'h04;
            7'h6D:   return 5'h05;
            7'h7D:   return 5'h06;
            7'h07:   return 5'h07;
            7'h7F:   return 5'h08;
            7'h6F:   return 5'h09;
            7'h77:   return 5'h0A;
            7'h7C:   return 5'h0B;
            7'h39:   return 5'h0C;
            7'h5E:   return 5'h0D;
            7'h79:   return 5'h0E;
            7'h71:   return 5'h0F;
            default: return 5'h10;
        endcase
    endfunction

    logic [6:0]          segs_p0_q, segs_p1_q;
    logic [DIGITS-1:0]   en_p0_q, en_p1_q;
    logic [3:0]          cnt_q, cnt_d;
    logic [DIGITS-1:0]   seen_q, seen_d, seen_set;
    logic [4*DIGITS-1:0] stage_val_q, stage_val_d;
    logic [DIGITS-1:0]   stage_inv_q, stage_inv_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   inv_q, inv_d;
    logic                valid_q, valid_d;

    logic                sel_p0, same_p0, capture, complete, load;
    logic [DIGITS-1:0]   hit_p0;
    logic [4:0]          dec_p0;

    // p0 -> p1: compare the registered sample with the one before it
    always_comb begin
        hit_p0  = ~en_p0_q;
        sel_p0  = one_hot(hit_p0);
        same_p0 = (segs_p0_q == segs_p1_q) && (en_p0_q == en_p1_q);
        dec_p0  = decode(segs_p0_q);

        cnt_d   = cnt_q;
        if (!sel_p0)
            cnt_d = 4'd0;
        else if (!same_p0)
            cnt_d = 4'd1;
        else if (cnt_q < STABLE_C)
            cnt_d = cnt_q + 4'd1;

        // A run changing digits restarts at 1, so STABLE_CYCLES==1 must not rely on cnt_q.
        capture = sel_p0 && (cnt_d == STABLE_C) && (!same_p0 || (cnt_q != STABLE_C));

        stage_val_d = stage_val_q;
        stage_inv_d = stage_inv_q;
        seen_set    = seen_q;
        if (capture) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (hit_p0[i]) begin
                    stage_val_d[4*i +: 4] = dec_p0[3:0];
                    stage_inv_d[i]        = dec_p0[4];
                    seen_set[i]           = 1'b1;
                end
            end
        end

        complete = capture && (&seen_set);
        seen_d   = complete ? '0 : seen_set;
        load     = complete && (!valid_q || value_ready);

        value_d = load ? stage_val_d : value_q;
        inv_d   = load ? stage_inv_d : inv_q;
        if (load)
            valid_d = 1'b1;
        else if (valid_q && value_ready)
            valid_d = 1'b0;
        else
            valid_d = valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            segs_p0_q   <= '0;
            en_p0_q     <= '1;
            segs_p1_q   <= '0;
            en_p1_q     <= '1;
            cnt_q       <= '0;
            seen_q      <= '0;
            stage_val_q <= '0;
            stage_inv_q <= '0;
            value_q     <= '0;
            inv_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            segs_p0_q   <= not_segs;
            en_p0_q     <= not_digit_en;
            segs_p1_q   <= segs_p0_q;
            en_p1_q     <= en_p0_q;
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
            stage_val_q <= stage_val_d;
            stage_inv_q <= stage_inv_d;
            value_q     <= value_d;
            inv_q       <= inv_d;
            valid_q     <= valid_d;
        end
    end

`ifdef SEG7_CAPTURE_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb overrun_d = overrun_q | (complete && valid_q && !value_ready);

    always_ff @(posedge clk) begin
        if (rst)
            overrun_q <= 1'b0;
        else
            overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign value        = value_q;
    assign invalid_mask = inv_q;
    assign value_valid  = valid_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture (DIGITS=4, STABLE_CYCLES=3).
module tb_seg7_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  not_segs;
    logic [3:0]  not_digit_en;
    logic [15:0] value;
    logic [3:0]  invalid_mask;
    logic        value_valid;
    logic        value_ready;
    logic        overrun;

    int errors = 0;
    int checks = 0;

`ifdef SEG7_CAPTURE_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    seg7_capture #(.DIGITS(4), .STABLE_CYCLES(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .not_segs     (not_segs),
        .not_digit_en (not_digit_en),
        .value        (value),
        .invalid_mask (invalid_mask),
        .value_valid  (value_valid),
        .value_ready  (value_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic [6:0] s);
        logic [3:0] m;
        m            = 4'b0001 << d;
        not_digit_en = ~m;
        not_segs     = s;
    endtask

    task automatic do_reset();
        not_digit_en = 4'b1111;
        not_segs     = 7'h7F;
        rst          = 1'b1;
        tick(1);
        rst          = 1'b0;
    endtask

    // Drives four digits 5 cycles each, leaving the last one held 4 cycles
    // so the completed frame is visible on return.
    task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        drive(0, s0); tick(5);
        drive(1, s1); tick(5);
        drive(2, s2); tick(5);
        drive(3, s3); tick(4);
    endtask

    initial begin
        rst          = 1'b1;
        not_segs     = 7'h7F;
        not_digit_en = 4'b1111;
        value_ready  = 1'b1;
        tick(2);
        chk("rst_value",   32'(value),        32'h0);
        chk("rst_mask",    32'(invalid_mask), 32'h0);
        chk("rst_valid",   32'(value_valid),  32'h0);
        chk("rst_overrun", 32'(overrun),      32'h0);
        rst = 1'b0;

        // Basic frame with exact latency on the last digit
        do_reset();
        drive(0, 7'h19); tick(5);
        drive(1, 7'h30); tick(5);
        drive(2, 7'h24); tick(5);
        drive(3, 7'h79); tick(3);
        chk("basic_valid_early", 32'(value_valid), 32'h0);
        tick(1);
        chk("basic_valid", 32'(value_valid),  32'h1);
        chk("basic_value", 32'(value),        32'h1234);
        chk("basic_mask",  32'(invalid_mask), 32'h0);
        tick(1);
        chk("basic_valid_drop", 32'(value_valid), 32'h0);

        // Glitch on the frame-completing digit: a short A must not finish the frame
        do_reset();
        drive(1, 7'h40); tick(5);
        drive(2, 7'h40); tick(5);
        drive(3, 7'h40); tick(5);
        chk("glitch_pre", 32'(value_valid), 32'h0);
        drive(0, 7'h08); tick(2);
        drive(0, 7'h0E); tick(3);
        chk("glitch_no_A", 32'(value_valid), 32'h0);
        tick(1);
        chk("glitch_valid", 32'(value_valid), 32'h1);
        chk("glitch_value", 32'(value),       32'h000F);

        // Blank glyph on digit 2
        do_reset();
        frame(7'h78, 7'h78, 7'h7F, 7'h78);
        chk("inv_valid", 32'(value_valid),  32'h1);
        chk("inv_value", 32'(value),        32'h7077);
        chk("inv_mask",  32'(invalid_mask), 32'h4);

        // Backpressure: second frame dropped while the first is held
        do_reset();
        value_ready = 1'b0;
        frame(7'h19, 7'h30, 7'h24, 7'h79);
        chk("bp_f1_valid",   32'(value_valid), 32'h1);
        chk("bp_f1_value",   32'(value),       32'h1234);
        chk("bp_f1_overrun", 32'(overrun),     32'h0);
        tick(1);
        frame(7'h12, 7'h02, 7'h00, 7'h10);
        tick(2);
        chk("bp_f2_valid",   32'(value_valid), 32'h1);
        chk("bp_f2_value",   32'(value),       32'h1234);
        chk("bp_f2_overrun", 32'(overrun),     32'(OVR_EXP));
        value_ready = 1'b1;
        tick(1);
        value_ready = 1'b0;
        chk("bp_release",      32'(value_valid), 32'h0);
        chk("bp_overrun_hold", 32'(overrun),     32'(OVR_EXP));
        frame(7'h12, 7'h02, 7'h00, 7'h10);
        chk("bp_f3_value", 32'(value),       32'h9865);
        chk("bp_f3_valid", 32'(value_valid), 32'h1);
        do_reset();
        chk("rst_pend_valid",   32'(value_valid), 32'h0);
        chk("rst_pend_value",   32'(value),       32'h0);
        chk("rst_pend_overrun", 32'(overrun),     32'h0);
        value_ready = 1'b1;

        // Reset mid-frame, including on the edge that captures digit 2
        do_reset();
        drive(0, 7'h19); tick(5);
        drive(1, 7'h30); tick(5);
        drive(2, 7'h24); tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        drive(3, 7'h79); tick(8);
        chk("midrst_valid", 32'(value_valid), 32'h0);
        chk("midrst_value", 32'(value),       32'h0);

        // Two digits selected at once is a blanking sample
        do_reset();
        not_digit_en = 4'b1100;
        not_segs     = 7'h19;
        tick(6);
        drive(1, 7'h30); tick(5);
        drive(2, 7'h24); tick(5);
        drive(3, 7'h79); tick(6);
        chk("dual_valid", 32'(value_valid), 32'h0);
        chk("dual_value", 32'(value),       32'h0);
        drive(0, 7'h19); tick(4);
        chk("dual_recover_valid", 32'(value_valid), 32'h1);
        chk("dual_recover_value", 32'(value),       32'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
